// File: rtl/lift_call_dispatch_if.sv
// Signal bundle between the call dispatcher and the lift controller.
// Handshake: the dispatcher raises butt_up_down_o with pass_f_o stable and holds
// both until it samples busy_i == 1 (the controller accepted the call) or gives up
// after ACK_TO cycles; busy_i then stays high until the car stands at pass_f_o.
interface lift_call_dispatch_if;
    logic [7:0] call_i;
    logic [2:0] elev_f_i;
    logic       busy_i;
    logic [2:0] pass_f_o;
    logic       butt_up_down_o;
    logic [7:0] pending_o;
    logic       dir_o;
    logic       arrived_o;
    logic       err_o;
    logic [2:0] state_dbg;

    // Lift-controller / button side.
    modport master (
        output call_i, elev_f_i, busy_i,
        input  pass_f_o, butt_up_down_o, pending_o, dir_o, arrived_o, err_o, state_dbg
    );

    // Dispatcher side.
    modport slave (
        input  call_i, elev_f_i, busy_i,
        output pass_f_o, butt_up_down_o, pending_o, dir_o, arrived_o, err_o, state_dbg
    );
endinterface

// File: rtl/lift_call_dispatch.sv
// Sweep (elevator-algorithm) dispatcher: latches floor calls, picks the nearest
// pending floor in the current sweep direction, hands it to the lift controller
// and holds the door for DWELL cycles once the car has arrived.
module lift_call_dispatch #(
    parameter int DWELL     = 4,
    parameter int ACK_TO    = 32,
    parameter int TRAVEL_TO = 255
) (
    input  logic              clk,
    input  logic              rst,
    lift_call_dispatch_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_TRAVEL = 3'd3,
        S_DOOR   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] call_eff, clr_mask;
    logic [2:0] target_q, target_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q;
    logic       door_entry;
    logic       up_found, dn_found;
    logic [2:0] up_floor, dn_floor;

    // The counter restarts on every state change, so cnt_q == 0 in DOOR marks its first cycle.
    assign door_entry = (state_q == S_DOOR) && (cnt_q == 8'd0);

    // Request latch: the floor the door is open at cannot re-latch; the served bit clears on entry.
    always_comb begin
        call_eff = bus.call_i;
        if (state_q == S_DOOR) begin
            call_eff = bus.call_i & ~(8'b1 << bus.elev_f_i);
        end
        clr_mask  = door_entry ? (8'b1 << target_q) : 8'b0;
        pending_d = (pending_q | call_eff) & ~clr_mask;
    end

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        up_found = 1'b0;
        up_floor = 3'd0;
        dn_found = 1'b0;
        dn_floor = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(bus.elev_f_i))) begin
                up_found = 1'b1;
                up_floor = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i] && (i < int'(bus.elev_f_i))) begin
                dn_found = 1'b1;
                dn_floor = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including target choice, sweep reversal and timeout fault.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 8'd0) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (pending_q == 8'd0) begin
                    state_d = S_IDLE;
                end else if (pending_q[bus.elev_f_i]) begin
                    target_d = bus.elev_f_i;
                    state_d  = S_DOOR;
                end else if (dir_q ? up_found : dn_found) begin
                    target_d = dir_q ? up_floor : dn_floor;
                    state_d  = S_ISSUE;
                end else begin
                    // Nothing ahead: reverse the sweep and take the nearest behind.
                    dir_d    = ~dir_q;
                    target_d = dir_q ? dn_floor : up_floor;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.busy_i) begin
                    state_d = S_TRAVEL;
                end else if (cnt_q == 8'(ACK_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TRAVEL: begin
                if ((bus.elev_f_i == target_q) && !bus.busy_i) begin
                    state_d = S_DOOR;
                end else if (cnt_q == 8'(TRAVEL_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DOOR: begin
                if (cnt_q == 8'(DWELL - 1)) state_d = S_SELECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: requests, target, direction, sticky fault, saturating state timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 8'd0;
            target_q  <= 3'd1;
            dir_q     <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            pending_q <= pending_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            if (state_d != state_q) begin
                cnt_q <= 8'd0;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Outputs.
    always_comb begin
        bus.pass_f_o       = target_q;
        bus.butt_up_down_o = (state_q == S_ISSUE);
        bus.pending_o      = pending_q;
        bus.dir_o          = dir_q;
        bus.arrived_o      = door_entry;
        bus.err_o          = err_q;
        bus.state_dbg      = state_q;
    end

endmodule

// File: tb/tb_lift_call_dispatch.sv
// Directed scenarios followed by randomized call sets checked against a sweep model.
module tb_lift_call_dispatch;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   m_dir;
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];

    lift_call_dispatch_if bus ();

    lift_call_dispatch #(.DWELL(4), .ACK_TO(32), .TRAVEL_TO(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pending"}, bus.pending_o, 8'h00);
        chk({tag, "_pass_f"}, {5'd0, bus.pass_f_o}, 8'd1);
        chk({tag, "_dir"}, {7'd0, bus.dir_o}, 8'd1);
        chk({tag, "_butt"}, {7'd0, bus.butt_up_down_o}, 8'd0);
        chk({tag, "_arrived"}, {7'd0, bus.arrived_o}, 8'd0);
        chk({tag, "_err"}, {7'd0, bus.err_o}, 8'd0);
    endtask

    // Lift-controller stand-in: accepts a call after a short random delay, moves the
    // car one floor every two cycles, drops busy on arrival; records served floors.
    task automatic run_lift(input int budget);
        int quiet = 0;
        int lphase = 0;
        int dly = 0;
        int mcnt = 0;
        int n = 0;
        logic [2:0] tgt = 3'd0;
        got_q.delete();
        while (quiet < 10 && n < budget) begin
            tick();
            n++;
            if (bus.arrived_o) got_q.push_back(bus.elev_f_i);
            case (lphase)
                0: if (bus.butt_up_down_o) begin
                    tgt = bus.pass_f_o;
                    dly = $urandom_range(0, 3);
                    lphase = 1;
                end
                1: if (dly == 0) begin
                    bus.busy_i = 1'b1;
                    mcnt = 0;
                    lphase = 2;
                end else begin
                    dly--;
                end
                default: if (bus.elev_f_i == tgt) begin
                    bus.busy_i = 1'b0;
                    lphase = 0;
                end else begin
                    mcnt++;
                    if (mcnt == 2) begin
                        mcnt = 0;
                        bus.elev_f_i = (tgt > bus.elev_f_i) ? bus.elev_f_i + 3'd1 : bus.elev_f_i - 3'd1;
                    end
                end
            endcase
            if (bus.arrived_o || bus.butt_up_down_o || bus.pending_o != 8'd0 || lphase != 0) quiet = 0;
            else quiet++;
        end
        chk("lift_budget", (n < budget) ? 8'd1 : 8'd0, 8'd1);
    endtask

    function automatic int nearest(input logic [7:0] s, input int f, input bit up);
        int r = -1;
        if (up) begin
            for (int i = 7; i > f; i--) if (s[i]) r = i;
        end else begin
            for (int i = 0; i < f; i++) if (s[i]) r = i;
        end
        return r;
    endfunction

    // Order in which a sweep from car floor serves the call set; updates m_dir.
    function automatic void model_sweep(input logic [2:0] car, input logic [7:0] calls);
        logic [7:0] s = calls;
        int f = int'(car);
        int pick;
        exp_q.delete();
        while (s != 8'd0) begin
            if (s[f]) begin
                pick = f;
            end else begin
                pick = nearest(s, f, m_dir);
                if (pick < 0) begin
                    m_dir = !m_dir;
                    pick = nearest(s, f, m_dir);
                end
            end
            exp_q.push_back(3'(pick));
            s[pick] = 1'b0;
            f = pick;
        end
    endfunction

    task automatic compare_order(input string tag);
        chk({tag, "_count"}, 8'(got_q.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_floor"}, {5'd0, got_q[i]}, {5'd0, exp_q[i]});
        end
    endtask

    initial begin
        logic [7:0] calls;
        rst = 1'b1;
        bus.call_i = 8'd0;
        bus.elev_f_i = 3'd1;
        bus.busy_i = 1'b0;
        repeat (3) tick();
        chk_reset_values("reset");
        rst = 1'b0;

        // Single call from floor 1 to floor 5.
        bus.call_i = 8'h20;
        tick();
        bus.call_i = 8'h00;
        chk("a_latch", bus.pending_o, 8'h20);
        tick();
        chk("a_no_strobe_in_select", {7'd0, bus.butt_up_down_o}, 8'd0);
        tick();
        chk("a_strobe", {7'd0, bus.butt_up_down_o}, 8'd1);
        chk("a_target", {5'd0, bus.pass_f_o}, 8'd5);
        chk("a_dir", {7'd0, bus.dir_o}, 8'd1);
        tick();
        chk("a_strobe_held", {7'd0, bus.butt_up_down_o}, 8'd1);
        bus.busy_i = 1'b1;
        tick();
        chk("a_strobe_dropped", {7'd0, bus.butt_up_down_o}, 8'd0);
        chk("a_target_travel", {5'd0, bus.pass_f_o}, 8'd5);
        bus.elev_f_i = 3'd3;
        tick();
        bus.elev_f_i = 3'd5;
        tick();
        chk("a_no_arrive_while_busy", {7'd0, bus.arrived_o}, 8'd0);
        bus.busy_i = 1'b0;
        tick();
        chk("a_arrived", {7'd0, bus.arrived_o}, 8'd1);
        tick();
        chk("a_arrived_pulse", {7'd0, bus.arrived_o}, 8'd0);
        chk("a_pending_clear", bus.pending_o, 8'h00);
        repeat (4) tick();

        // Call at the car's own floor goes straight to the door; door lasts 4 cycles.
        bus.elev_f_i = 3'd2;
        bus.call_i = 8'h04;
        tick();
        bus.call_i = 8'h00;
        tick();
        tick();
        chk("b_arrived", {7'd0, bus.arrived_o}, 8'd1);
        chk("b_no_issue", {7'd0, bus.butt_up_down_o}, 8'd0);
        bus.call_i = 8'h44;
        tick();
        chk("b_arrived_pulse", {7'd0, bus.arrived_o}, 8'd0);
        repeat (3) tick();
        bus.call_i = 8'h00;
        chk("b_door_strobe_low", {7'd0, bus.butt_up_down_o}, 8'd0);
        chk("b_door_floor_masked", bus.pending_o, 8'h40);
        tick();
        chk("b_issue_after_dwell", {7'd0, bus.butt_up_down_o}, 8'd1);
        chk("b_target", {5'd0, bus.pass_f_o}, 8'd6);

        // No acknowledge: fault after 32 cycles in ISSUE.
        repeat (31) tick();
        chk("c_err_not_early", {7'd0, bus.err_o}, 8'd0);
        chk("c_strobe_before_to", {7'd0, bus.butt_up_down_o}, 8'd1);
        tick();
        chk("c_err_set", {7'd0, bus.err_o}, 8'd1);
        chk("c_strobe_dropped", {7'd0, bus.butt_up_down_o}, 8'd0);
        chk("c_pending_kept", bus.pending_o, 8'h40);
        run_lift(600);
        chk("c_served_after_err", 8'(got_q.size()), 8'd1);
        if (got_q.size() > 0) chk("c_served_floor", {5'd0, got_q[0]}, 8'd6);
        chk("c_err_sticky", {7'd0, bus.err_o}, 8'd1);

        // Car at 3 going up, calls {1,6}: 6 then 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_values("reset2");
        bus.elev_f_i = 3'd3;
        bus.call_i = 8'h42;
        tick();
        bus.call_i = 8'h00;
        run_lift(1000);
        chk("d_count", 8'(got_q.size()), 8'd2);
        if (got_q.size() == 2) begin
            chk("d_first", {5'd0, got_q[0]}, 8'd6);
            chk("d_second", {5'd0, got_q[1]}, 8'd1);
        end
        chk("d_dir_down", {7'd0, bus.dir_o}, 8'd0);

        // Call during travel to 4 does not retarget; reset mid-travel aborts.
        bus.call_i = 8'h10;
        tick();
        bus.call_i = 8'h00;
        tick();
        tick();
        chk("e_strobe", {7'd0, bus.butt_up_down_o}, 8'd1);
        chk("e_target", {5'd0, bus.pass_f_o}, 8'd4);
        chk("e_dir_flipped", {7'd0, bus.dir_o}, 8'd1);
        bus.busy_i = 1'b1;
        tick();
        bus.call_i = 8'h80;
        tick();
        bus.call_i = 8'h00;
        chk("e_late_call_latched", bus.pending_o, 8'h90);
        bus.elev_f_i = 3'd2;
        tick();
        bus.elev_f_i = 3'd3;
        tick();
        chk("e_target_kept", {5'd0, bus.pass_f_o}, 8'd4);
        bus.elev_f_i = 3'd4;
        tick();
        bus.busy_i = 1'b0;
        tick();
        chk("e_arrived", {7'd0, bus.arrived_o}, 8'd1);
        chk("e_arrived_floor", {5'd0, bus.pass_f_o}, 8'd4);
        tick();
        chk("e_pending_after", bus.pending_o, 8'h80);
        repeat (4) tick();
        chk("e_next_strobe", {7'd0, bus.butt_up_down_o}, 8'd1);
        chk("e_next_target", {5'd0, bus.pass_f_o}, 8'd7);
        bus.busy_i = 1'b1;
        tick();
        rst = 1'b1;
        bus.call_i = 8'h01;
        tick();
        chk_reset_values("reset_mid");
        rst = 1'b0;
        bus.call_i = 8'h00;
        bus.busy_i = 1'b0;
        tick();
        chk("e_call_on_reset_dropped", bus.pending_o, 8'h00);

        // Randomized call sets against the sweep model.
        m_dir = 1'b1;
        for (int r = 0; r < 20; r++) begin
            bus.elev_f_i = 3'($urandom_range(0, 7));
            calls = 8'($urandom_range(1, 255));
            model_sweep(bus.elev_f_i, calls);
            bus.call_i = calls;
            tick();
            bus.call_i = 8'h00;
            run_lift(2000);
            compare_order("rand");
            chk("rand_pending", bus.pending_o, 8'h00);
            chk("rand_dir", {7'd0, bus.dir_o}, {7'd0, m_dir});
            chk("rand_err", {7'd0, bus.err_o}, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_call_dispatch.md
LIFT_CALL_DISPATCH -- requirements
Module: lift_call_dispatch

Interface
REQ-001 Parameter DWELL, default 4: door-dwell cycles spent at a served floor; legal range 1..255.
REQ-002 Parameter ACK_TO, default 32: maximum cycles to wait for busy_i after a call is issued; legal range 1..255.
REQ-003 Parameter TRAVEL_TO, default 255: maximum cycles to wait in TRAVEL for arrival; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 call_i  input  8  floor-call buttons (hall and car combined), bit n = floor n, level-sampled every cycle.
REQ-007 elev_f_i  input  3  current car floor reported by the lift controller.
REQ-008 busy_i  input  1  lift controller busy (1) / free (0).
REQ-009 pass_f_o  output  3  target floor presented to the lift controller.
REQ-010 butt_up_down_o  output  1  call strobe to the lift controller; high only in ISSUE.
REQ-011 pending_o  output  8  latched outstanding requests.
REQ-012 dir_o  output  1  sweep direction: 1 = up, 0 = down.
REQ-013 arrived_o  output  1  one-cycle pulse when a target floor is served.
REQ-014 err_o  output  1  sticky fault flag: ACK_TO or TRAVEL_TO expired.

Function
REQ-015 Pending latch: each cycle pending <= (pending | call_i) & ~clr_mask; clr_mask is the served-floor bit on the DOOR entry cycle, zero otherwise.
REQ-016 While in DOOR, call_i bit for elev_f_i is masked (not latched); calls for other floors always latch.
REQ-017 States: IDLE, SELECT, ISSUE, TRAVEL, DOOR; state encoding is free.
REQ-018 IDLE: if pending == 0, remain; else go to SELECT next cycle.
REQ-019 SELECT (1 cycle): if pending bit elev_f_i is set, target <= elev_f_i and go to DOOR.
REQ-020 SELECT otherwise picks the nearest pending floor strictly in dir_o direction; if none exists, dir_o toggles and the nearest floor in the new direction is picked, all in the same cycle.
REQ-021 SELECT with pending == 0 (cleared by a race) returns to IDLE.
REQ-022 ISSUE: pass_f_o = target and butt_up_down_o = 1 are held until busy_i == 1 is sampled, then go to TRAVEL.
REQ-023 ISSUE timeout: after ACK_TO cycles without busy_i, set err_o, drop butt_up_down_o, go to IDLE with pending unchanged.
REQ-024 TRAVEL: pass_f_o holds target; when elev_f_i == target and busy_i == 0, go to DOOR.
REQ-025 TRAVEL timeout: after TRAVEL_TO cycles, set err_o and go to IDLE with pending unchanged.
REQ-026 DOOR entry cycle: arrived_o = 1 and pending[target] is cleared.
REQ-027 DOOR: stay DWELL cycles total, counted from entry, then go to SELECT.
REQ-028 Calls arriving during ISSUE or TRAVEL only latch; target is never changed mid-flight.
REQ-029 Timeout counters are 8-bit, reset on every state entry, and saturate rather than wrap.
REQ-030 err_o stays set until rst; dispatching continues normally while err_o = 1.

Reset
REQ-031 rst = 1 at a clock edge forces IDLE, pending = 0, pass_f_o = 3'd1, dir_o = 1, butt_up_down_o = 0, arrived_o = 0, err_o = 0, all counters 0.
REQ-032 rst asserted mid-ISSUE, TRAVEL or DOOR aborts the operation; call_i seen on that edge is discarded.
REQ-033 First call_i sampling occurs on the first edge with rst = 0.

Verification
REQ-034 Reset, elev_f_i = 1, busy_i = 0, pulse call_i[5] -> SELECT picks 5 with dir_o = 1; ISSUE drives pass_f_o = 5 and butt_up_down_o = 1 until busy_i rises; model reaches 5 with busy_i = 0 -> arrived_o pulse, pending_o = 0.
REQ-035 Car at 3, dir_o = 1, pending floors {1, 6} -> serves 6 first, then dir_o flips to 0 and serves 1; arrived_o pulses twice, in that order.
REQ-036 Car at 2 in IDLE, call_i[2] pulsed -> SELECT goes straight to DOOR, no ISSUE; arrived_o pulses and DOOR lasts exactly DWELL = 4 cycles.
REQ-037 busy_i held 0 after a call is issued -> err_o = 1 exactly ACK_TO = 32 cycles after ISSUE entry, pending bit kept, butt_up_down_o = 0.
REQ-038 call_i[7] pressed during TRAVEL to 4 -> target stays 4; after DOOR, 7 is selected next; rst mid-TRAVEL -> all outputs at REQ-031 values on the next cycle.
